// File: rtl/seg7_scan_driver_if.sv
// Bus bundle for the 4-digit 7-segment scan driver.
// The master side supplies the control and data; the slave side is the driver.
interface seg7_scan_driver_if;
   logic        enable;
   logic        load;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic        lz_en;
   logic        pending;
   logic        frame_done;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;

   modport master (
      output enable, load, data_in, dp_in, lz_en,
      input  pending, frame_done, an_n, seg_n, dp_n
   );

   modport slave (
      input  enable, load, data_in, dp_in, lz_en,
      output pending, frame_done, an_n, seg_n, dp_n
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A shadow register captures new words; the active register that feeds the
// decoder only changes at a frame boundary (or while the display is off),
// so a frame is never drawn from two different words.
module seg7_scan_driver #(
   parameter int CLK_DIV     = 50000,
   parameter int GHOST_BLANK = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seg7_scan_driver_if.slave    bus
);

   localparam int              PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0]   BLANK_END = PW'(GHOST_BLANK);

   // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         4'hF:    seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

   logic [15:0]   r_shadow;
   logic [3:0]    r_shadow_dp;
   logic [15:0]   r_active;
   logic [3:0]    r_active_dp;
   logic          r_pending;
   logic [PW-1:0] r_presc;
   logic [1:0]    r_idx;
   logic [3:0]    r_an_n;
   logic [6:0]    r_seg_n;
   logic          r_dp_n;
   logic          r_frame_done;

   logic          w_tick;
   logic          w_boundary;
   logic          w_xfer;
   logic [3:0]    w_nibble;
   logic          w_z3;
   logic          w_z2;
   logic          w_z1;
   logic          w_suppress;
   logic [6:0]    w_seg;
   logic [3:0]    w_an;
   logic          w_dp;

   assign w_tick     = bus.enable && (r_presc == PRESC_MAX);
   assign w_boundary = w_tick && (r_idx == 2'd3);
   // While the display is off nothing can tear, so a pending word moves at once.
   assign w_xfer     = r_pending && (w_boundary || !bus.enable);

   // Leading-zero chain: a digit is blank only if it and every digit left of it is zero.
   assign w_z3 = (r_active[15:12] == 4'h0);
   assign w_z2 = w_z3 && (r_active[11:8] == 4'h0);
   assign w_z1 = w_z2 && (r_active[7:4] == 4'h0);

   // Select the nibble and suppression flag of the digit currently scanned.
   always_comb begin
      w_nibble   = 4'h0;
      w_suppress = 1'b0;
      case (r_idx)
         2'd0: begin
            w_nibble   = r_active[3:0];
            w_suppress = 1'b0;
         end
         2'd1: begin
            w_nibble   = r_active[7:4];
            w_suppress = bus.lz_en && w_z1;
         end
         2'd2: begin
            w_nibble   = r_active[11:8];
            w_suppress = bus.lz_en && w_z2;
         end
         2'd3: begin
            w_nibble   = r_active[15:12];
            w_suppress = bus.lz_en && w_z3;
         end
         default: begin
            w_nibble   = 4'h0;
            w_suppress = 1'b0;
         end
      endcase
   end

   // Next display pattern: anodes blanked at the start of each slot, segments always decoded.
   always_comb begin
      w_seg = 7'h7F;
      w_an  = 4'hF;
      if (w_suppress) begin
         w_seg = 7'h7F;
      end else begin
         w_seg = hex_to_seg(w_nibble);
      end
      if (r_presc < BLANK_END) begin
         w_an = 4'hF;
      end else begin
         w_an = ~(4'b0001 << r_idx);
      end
   end

   assign w_dp = r_active_dp[r_idx];

   // Slot prescaler and digit index; both parked at zero while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= 2'd0;
      end else if (!bus.enable) begin
         r_presc <= '0;
         r_idx   <= 2'd0;
      end else if (w_tick) begin
         r_presc <= '0;
         r_idx   <= r_idx + 2'd1;
      end else begin
         r_presc <= r_presc + PW'(1);
         r_idx   <= r_idx;
      end
   end

   // Double buffer: a load always wins the pending flag, the transfer takes the old shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow    <= 16'h0000;
         r_shadow_dp <= 4'h0;
         r_active    <= 16'h0000;
         r_active_dp <= 4'h0;
         r_pending   <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_active    <= r_shadow;
            r_active_dp <= r_shadow_dp;
         end
         if (bus.load) begin
            r_shadow    <= bus.data_in;
            r_shadow_dp <= bus.dp_in;
            r_pending   <= 1'b1;
         end else if (w_xfer) begin
            r_pending   <= 1'b0;
         end
      end
   end

   // Registered display outputs and frame pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an_n       <= 4'hF;
         r_seg_n      <= 7'h7F;
         r_dp_n       <= 1'b1;
         r_frame_done <= 1'b0;
      end else if (!bus.enable) begin
         r_an_n       <= 4'hF;
         r_seg_n      <= 7'h7F;
         r_dp_n       <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_an_n       <= w_an;
         r_seg_n      <= w_seg;
         r_dp_n       <= ~w_dp;
         r_frame_done <= w_boundary;
      end
   end

   assign bus.an_n       = r_an_n;
   assign bus.seg_n      = r_seg_n;
   assign bus.dp_n       = r_dp_n;
   assign bus.frame_done = r_frame_done;
   assign bus.pending    = r_pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (CLK_DIV=4, GHOST_BLANK=1).
// Stimulus pushes the hand-decoded slots of the frame it expects next;
// a monitor pops one entry each time a lit slot begins.
module tb_seg7_scan_driver;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } slot_t;

   logic  clk;
   logic  rst_n;
   int    checks;
   int    errors;
   slot_t exp_q[$];

   seg7_scan_driver_if u_if ();

   seg7_scan_driver #(.CLK_DIV(4), .GHOST_BLANK(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Expected frame: digits 0..3 with their segment patterns and dp_n bits.
   task automatic push4(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3,
                        input logic [3:0] dpn);
      exp_q.push_back('{an: 4'hE, seg: s0, dp: dpn[0]});
      exp_q.push_back('{an: 4'hD, seg: s1, dp: dpn[1]});
      exp_q.push_back('{an: 4'hB, seg: s2, dp: dpn[2]});
      exp_q.push_back('{an: 4'h7, seg: s3, dp: dpn[3]});
   endtask

   task automatic load_word(input logic [15:0] d, input logic [3:0] dp);
      u_if.load    = 1'b1;
      u_if.data_in = d;
      u_if.dp_in   = dp;
      @(negedge clk);
      u_if.load    = 1'b0;
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (u_if.frame_done !== 1'b1 && n < 100);
      if (u_if.frame_done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL frame_wait actual=timeout required=frame_done");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain actual=%0d_left required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: a lit slot starts when an_n leaves all-high.
   initial begin
      logic [3:0] prev_an;
      slot_t      e;
      prev_an = 4'hF;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && u_if.an_n !== 4'hF && prev_an === 4'hF && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("slot_an", 32'(u_if.an_n), 32'(e.an));
            chk("slot_seg", 32'(u_if.seg_n), 32'(e.seg));
            chk("slot_dp", 32'(u_if.dp_n), 32'(e.dp));
         end
         prev_an = u_if.an_n;
      end
   end

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      u_if.enable  = 1'b1;
      u_if.load    = 1'b0;
      u_if.data_in = 16'h0000;
      u_if.dp_in   = 4'h0;
      u_if.lz_en   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an", 32'(u_if.an_n), 32'h0000000F);
      chk("rst_seg", 32'(u_if.seg_n), 32'h0000007F);
      rst_n = 1'b1;

      // Reset mid-scan with a pending word.
      repeat (5) @(negedge clk);
      load_word(16'h1111, 4'hF);
      chk("pend_set", 32'(u_if.pending), 32'h1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_an", 32'(u_if.an_n), 32'h0000000F);
      chk("async_seg", 32'(u_if.seg_n), 32'h0000007F);
      chk("async_dp", 32'(u_if.dp_n), 32'h1);
      chk("async_pend", 32'(u_if.pending), 32'h0);
      chk("async_fd", 32'(u_if.frame_done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_blank", 32'(u_if.an_n), 32'h0000000F);
      @(negedge clk);
      chk("rel_an", 32'(u_if.an_n), 32'h0000000E);
      chk("rel_seg", 32'(u_if.seg_n), 32'h00000040);

      // 1A8F with decimal point on digit 2.
      wait_frame();
      load_word(16'h1A8F, 4'b0100);
      chk("pend_1a8f", 32'(u_if.pending), 32'h1);
      wait_frame();
      chk("pend_clr_1a8f", 32'(u_if.pending), 32'h0);
      push4(7'h0E, 7'h00, 7'h08, 7'h79, 4'b1011);

      // Mid-frame load: the old word finishes its frame.
      wait_frame();
      push4(7'h0E, 7'h00, 7'h08, 7'h79, 4'b1011);
      repeat (5) @(negedge clk);
      load_word(16'h1234, 4'h0);
      chk("pend_1234", 32'(u_if.pending), 32'h1);
      wait_frame();
      chk("pend_clr_1234", 32'(u_if.pending), 32'h0);
      push4(7'h19, 7'h30, 7'h24, 7'h79, 4'hF);

      // Two loads within one frame: only the last is shown.
      repeat (3) @(negedge clk);
      load_word(16'h5555, 4'h0);
      repeat (3) @(negedge clk);
      load_word(16'hAAAA, 4'h0);
      chk("pend_aaaa", 32'(u_if.pending), 32'h1);
      wait_frame();
      chk("pend_clr_aaaa", 32'(u_if.pending), 32'h0);
      push4(7'h08, 7'h08, 7'h08, 7'h08, 4'hF);

      // Load landing on the boundary edge: BEEF transfers, C0DE stays pending.
      repeat (3) @(negedge clk);
      load_word(16'hBEEF, 4'h0);
      repeat (11) @(negedge clk);
      load_word(16'hC0DE, 4'h0);
      chk("simul_fd", 32'(u_if.frame_done), 32'h1);
      chk("simul_pend", 32'(u_if.pending), 32'h1);
      push4(7'h0E, 7'h06, 7'h06, 7'h03, 4'hF);
      wait_frame();
      chk("pend_clr_c0de", 32'(u_if.pending), 32'h0);
      push4(7'h06, 7'h21, 7'h40, 7'h46, 4'hF);

      // Leading-zero suppression.
      wait_frame();
      u_if.lz_en = 1'b1;
      load_word(16'h0050, 4'h0);
      wait_frame();
      push4(7'h40, 7'h12, 7'h7F, 7'h7F, 4'hF);
      load_word(16'h0000, 4'h0);
      wait_frame();
      push4(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF);
      wait_frame();
      u_if.lz_en = 1'b0;

      // Disable mid-slot with a pending word, then re-enable.
      load_word(16'h4321, 4'h0);
      @(negedge clk);
      @(negedge clk);
      u_if.enable = 1'b0;
      @(negedge clk);
      chk("dis_an", 32'(u_if.an_n), 32'h0000000F);
      chk("dis_seg", 32'(u_if.seg_n), 32'h0000007F);
      chk("dis_dp", 32'(u_if.dp_n), 32'h1);
      chk("dis_pend", 32'(u_if.pending), 32'h0);
      repeat (6) @(negedge clk);
      chk("dis_hold_an", 32'(u_if.an_n), 32'h0000000F);
      chk("dis_hold_fd", 32'(u_if.frame_done), 32'h0);
      push4(7'h79, 7'h24, 7'h30, 7'h19, 4'hF);
      u_if.enable = 1'b1;
      @(negedge clk);
      chk("reen_blank", 32'(u_if.an_n), 32'h0000000F);
      @(negedge clk);
      chk("reen_an", 32'(u_if.an_n), 32'h0000000E);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
